// File: rtl/register_bank_arbiter_pkg.sv
// Shared encodings and types for the two-master register bank arbiter.
package register_bank_arbiter_pkg;

  localparam int ADDR_W   = 2;
  localparam int DATA_W   = 8;
  localparam int NUM_REGS = 4;

  // Arbiter state encodings
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_OWN_A = 2'd1;
  localparam logic [1:0] ST_OWN_B = 2'd2;

  // last_owner encoding: which side most recently gave up the bank
  localparam logic OWNER_A = 1'b0;
  localparam logic OWNER_B = 1'b1;

  // One requester's access bundle
  typedef struct packed {
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } bank_req_t;

  // One-hot decode of a register index
  function automatic logic [NUM_REGS-1:0] addr_dec(input logic [ADDR_W-1:0] addr);
    logic [NUM_REGS-1:0] oh;
    oh       = '0;
    oh[addr] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/eight_bit_register.sv
// Plain 8-bit storage element: loads d on every rising edge, clears on reset.
module eight_bit_register (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] d,
  output logic [7:0] q
);

  // Unconditional load; hold behaviour is the caller's job
  always_ff @(posedge clk) begin
    if (rst) q <= 8'h00;
    else     q <= d;
  end

endmodule

// File: rtl/register_hold_slot.sv
// One bank entry: an always-loading register with a hold-or-load mux in front.
module register_hold_slot
  import register_bank_arbiter_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load_en,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] q
);

  logic [DATA_W-1:0] d;

  // Feed the register its own output unless this slot is being written
  always_comb begin
    d = load_en ? wdata : q;
  end

  eight_bit_register u_reg (
    .clk (clk),
    .rst (rst),
    .d   (d),
    .q   (q)
  );

endmodule

// File: rtl/register_bank_arbiter.sv
// Round-robin arbiter sharing a 4-entry register bank between masters A and B.
// The grant is registered; an owner keeps the bank for at most MAX_BURST
// back-to-back accesses while the other side waits, and handover is free.
module register_bank_arbiter
  import register_bank_arbiter_pkg::*;
#(
  parameter int MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_a,
  input  logic              we_a,
  input  logic [ADDR_W-1:0] addr_a,
  input  logic [DATA_W-1:0] wdata_a,
  output logic              gnt_a,
  output logic              rvalid_a,
  output logic [DATA_W-1:0] rdata_a,
  input  logic              req_b,
  input  logic              we_b,
  input  logic [ADDR_W-1:0] addr_b,
  input  logic [DATA_W-1:0] wdata_b,
  output logic              gnt_b,
  output logic              rvalid_b,
  output logic [DATA_W-1:0] rdata_b
);

  localparam logic [3:0] BURST_LAST = 4'(MAX_BURST - 1);

  logic [1:0] state, state_nxt;
  logic [3:0] count, count_nxt;
  logic       last_owner, last_owner_nxt;

  bank_req_t  side_a, side_b, own;
  logic       acc_a, acc_b, acc;

  logic [NUM_REGS-1:0]             load_en;
  logic [NUM_REGS-1:0][DATA_W-1:0] reg_q;
  logic [DATA_W-1:0]               rd_word;

  assign side_a = '{req: req_a, we: we_a, addr: addr_a, wdata: wdata_a};
  assign side_b = '{req: req_b, we: we_b, addr: addr_b, wdata: wdata_b};

  // Grants come straight from registered state, so they are mutually exclusive
  assign gnt_a = (state == ST_OWN_A);
  assign gnt_b = (state == ST_OWN_B);

  assign acc_a = gnt_a & req_a;
  assign acc_b = gnt_b & req_b;
  assign acc   = acc_a | acc_b;

  // Single bank port: the owner's bundle; the non-owner is never looked at
  assign own     = gnt_b ? side_b : side_a;
  assign rd_word = reg_q[own.addr];

  // Next-state, burst count and fairness bookkeeping
  always_comb begin
    state_nxt      = state;
    count_nxt      = count;
    last_owner_nxt = last_owner;
    case (state)
      ST_IDLE: begin
        count_nxt = 4'd0;
        if (req_a && (!req_b || last_owner == OWNER_B)) state_nxt = ST_OWN_A;
        else if (req_b)                                 state_nxt = ST_OWN_B;
      end
      ST_OWN_A: begin
        if (req_a) begin
          if (count == BURST_LAST && req_b) begin
            state_nxt      = ST_OWN_B;
            count_nxt      = 4'd0;
            last_owner_nxt = OWNER_A;
          end else if (count != BURST_LAST) begin
            count_nxt = count + 4'd1;
          end
        end else begin
          state_nxt      = req_b ? ST_OWN_B : ST_IDLE;
          count_nxt      = 4'd0;
          last_owner_nxt = OWNER_A;
        end
      end
      ST_OWN_B: begin
        if (req_b) begin
          if (count == BURST_LAST && req_a) begin
            state_nxt      = ST_OWN_A;
            count_nxt      = 4'd0;
            last_owner_nxt = OWNER_B;
          end else if (count != BURST_LAST) begin
            count_nxt = count + 4'd1;
          end
        end else begin
          state_nxt      = req_a ? ST_OWN_A : ST_IDLE;
          count_nxt      = 4'd0;
          last_owner_nxt = OWNER_B;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        count_nxt = 4'd0;
      end
    endcase
  end

  // Arbiter state registers; B starts as last owner so A wins the first tie
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      count      <= 4'd0;
      last_owner <= OWNER_B;
    end else begin
      state      <= state_nxt;
      count      <= count_nxt;
      last_owner <= last_owner_nxt;
    end
  end

  // Write strobe for the addressed slot only during an owner's write access
  always_comb begin
    load_en = (acc && own.we) ? addr_dec(own.addr) : '0;
  end

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_slot
    register_hold_slot u_slot (
      .clk     (clk),
      .rst     (rst),
      .load_en (load_en[i]),
      .wdata   (own.wdata),
      .q       (reg_q[i])
    );
  end

  // Read return: one-cycle valid pulse, data held between reads
  always_ff @(posedge clk) begin
    if (rst) begin
      rvalid_a <= 1'b0;
      rvalid_b <= 1'b0;
      rdata_a  <= '0;
      rdata_b  <= '0;
    end else begin
      rvalid_a <= acc_a & ~we_a;
      rvalid_b <= acc_b & ~we_b;
      if (acc_a && !we_a) rdata_a <= rd_word;
      if (acc_b && !we_b) rdata_b <= rd_word;
    end
  end

endmodule

// File: tb/tb_register_bank_arbiter.sv
// Bench for register_bank_arbiter: directed scenarios then random traffic,
// two instances (MAX_BURST=4 and MAX_BURST=1) checked against a simple model.
module tb_register_bank_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic req_a = 1'b0, we_a = 1'b0, req_b = 1'b0, we_b = 1'b0;
  logic [1:0] addr_a = '0, addr_b = '0;
  logic [7:0] wdata_a = '0, wdata_b = '0;

  logic [1:0]      gnt_a_o, gnt_b_o, rv_a_o, rv_b_o;
  logic [1:0][7:0] rd_a_o, rd_b_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  register_bank_arbiter #(.MAX_BURST(4)) dut (
    .clk(clk), .rst(rst),
    .req_a(req_a), .we_a(we_a), .addr_a(addr_a), .wdata_a(wdata_a),
    .gnt_a(gnt_a_o[0]), .rvalid_a(rv_a_o[0]), .rdata_a(rd_a_o[0]),
    .req_b(req_b), .we_b(we_b), .addr_b(addr_b), .wdata_b(wdata_b),
    .gnt_b(gnt_b_o[0]), .rvalid_b(rv_b_o[0]), .rdata_b(rd_b_o[0])
  );

  register_bank_arbiter #(.MAX_BURST(1)) dut1 (
    .clk(clk), .rst(rst),
    .req_a(req_a), .we_a(we_a), .addr_a(addr_a), .wdata_a(wdata_a),
    .gnt_a(gnt_a_o[1]), .rvalid_a(rv_a_o[1]), .rdata_a(rd_a_o[1]),
    .req_b(req_b), .we_b(we_b), .addr_b(addr_b), .wdata_b(wdata_b),
    .gnt_b(gnt_b_o[1]), .rvalid_b(rv_b_o[1]), .rdata_b(rd_b_o[1])
  );

  // Reference model, one per instance. owner: 0 none, 1 A, 2 B.
  // used = accesses performed by the current owner in this burst.
  int         m_mb    [2] = '{4, 1};
  int         m_owner [2];
  int         m_used  [2];
  int         m_last  [2];
  logic [7:0] m_regs  [2][4];
  logic       m_rva   [2], m_rvb [2];
  logic [7:0] m_rda   [2], m_rdb [2];
  bit         m_valid = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
  endtask

  task automatic model_step(input int i);
    bit acc_a, acc_b;
    if (rst) begin
      m_owner[i] = 0; m_used[i] = 0; m_last[i] = 2;
      for (int r = 0; r < 4; r++) m_regs[i][r] = 8'h00;
      m_rva[i] = 0; m_rvb[i] = 0; m_rda[i] = 8'h00; m_rdb[i] = 8'h00;
      return;
    end
    acc_a = (m_owner[i] == 1) && req_a;
    acc_b = (m_owner[i] == 2) && req_b;
    m_rva[i] = acc_a && !we_a;
    m_rvb[i] = acc_b && !we_b;
    if (m_rva[i]) m_rda[i] = m_regs[i][addr_a];
    if (m_rvb[i]) m_rdb[i] = m_regs[i][addr_b];
    if (acc_a && we_a) m_regs[i][addr_a] = wdata_a;
    if (acc_b && we_b) m_regs[i][addr_b] = wdata_b;
    case (m_owner[i])
      0: begin
        m_used[i] = 0;
        if (req_a && req_b) m_owner[i] = (m_last[i] == 1) ? 2 : 1;
        else if (req_a)     m_owner[i] = 1;
        else if (req_b)     m_owner[i] = 2;
      end
      1: begin
        if (req_a) begin
          m_used[i]++;
          if (m_used[i] >= m_mb[i] && req_b) begin
            m_owner[i] = 2; m_used[i] = 0; m_last[i] = 1;
          end
        end else begin
          m_owner[i] = req_b ? 2 : 0; m_used[i] = 0; m_last[i] = 1;
        end
      end
      default: begin
        if (req_b) begin
          m_used[i]++;
          if (m_used[i] >= m_mb[i] && req_a) begin
            m_owner[i] = 1; m_used[i] = 0; m_last[i] = 2;
          end
        end else begin
          m_owner[i] = req_a ? 1 : 0; m_used[i] = 0; m_last[i] = 2;
        end
      end
    endcase
  endtask

  // One clock: compare all outputs mid-cycle, advance the model, pass the edge
  task automatic tick();
    @(negedge clk);
    if (m_valid) begin
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("gnt_a[%0d]", i),    32'(gnt_a_o[i]), 32'(m_owner[i] == 1));
        chk($sformatf("gnt_b[%0d]", i),    32'(gnt_b_o[i]), 32'(m_owner[i] == 2));
        chk($sformatf("rvalid_a[%0d]", i), 32'(rv_a_o[i]),  32'(m_rva[i]));
        chk($sformatf("rvalid_b[%0d]", i), 32'(rv_b_o[i]),  32'(m_rvb[i]));
        chk($sformatf("rdata_a[%0d]", i),  32'(rd_a_o[i]),  32'(m_rda[i]));
        chk($sformatf("rdata_b[%0d]", i),  32'(rd_b_o[i]),  32'(m_rdb[i]));
      end
    end
    for (int i = 0; i < 2; i++) model_step(i);
    @(posedge clk);
    #1;
    if (rst) m_valid = 1;
  endtask

  task automatic do_reset();
    rst = 1; req_a = 0; req_b = 0;
    tick(); tick();
    rst = 0;
  endtask

  initial begin
    // 1: reset then idle, read of addr 2 returns zero
    do_reset();
    chk("rst_gnt_a", 32'(gnt_a_o[0]), 0);
    chk("rst_gnt_b", 32'(gnt_b_o[0]), 0);
    chk("rst_rvalid_a", 32'(rv_a_o[0]), 0);
    chk("rst_rdata_b", 32'(rd_b_o[0]), 0);
    tick();
    req_a = 1; we_a = 0; addr_a = 2;
    tick();
    chk("t1_gnt_a", 32'(gnt_a_o[0]), 1);
    tick();
    chk("t1_rvalid", 32'(rv_a_o[0]), 1);
    chk("t1_rdata", 32'(rd_a_o[0]), 32'h00);
    req_a = 0;
    tick(); tick();

    // 2: write A5 to addr 1, read it back
    req_a = 1; we_a = 1; addr_a = 1; wdata_a = 8'hA5;
    tick();
    chk("t2_gnt_a", 32'(gnt_a_o[0]), 1);
    tick();
    we_a = 0;
    tick();
    chk("t2_rvalid", 32'(rv_a_o[0]), 1);
    chk("t2_rdata", 32'(rd_a_o[0]), 32'hA5);
    req_a = 0;
    tick();
    chk("t2_rvalid_drop", 32'(rv_a_o[0]), 0);
    chk("t2_rdata_hold", 32'(rd_a_o[0]), 32'hA5);
    tick();

    // 3 + 4: simultaneous request after reset; A first, then burst handover
    do_reset();
    req_a = 1; we_a = 1; addr_a = 0; wdata_a = 8'h11;
    req_b = 1; we_b = 1; addr_b = 1; wdata_b = 8'h22;
    tick();
    chk("t3_first_a", 32'(gnt_a_o[0]), 1);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("t3_burst_a%0d", k), 32'(gnt_a_o[0]), 1);
      chk($sformatf("t4_alt%0d", k), 32'(gnt_a_o[1]), 32'(k % 2 == 0));
      addr_a = 2'(k); wdata_a = 8'(8'h40 + k);
      addr_b = 2'(3 - k); wdata_b = 8'(8'h80 + k);
      tick();
    end
    chk("t3_handover_b", 32'(gnt_b_o[0]), 1);
    for (int k = 0; k < 4; k++) tick();
    req_a = 0; req_b = 0;
    tick(); tick();
    // read back all four addresses through A
    req_a = 1; we_a = 0;
    for (int k = 0; k < 5; k++) begin
      addr_a = 2'(k);
      tick();
    end
    req_a = 0;
    tick(); tick();

    // 5: early release hands over without a dead cycle
    do_reset();
    req_a = 1; we_a = 1; addr_a = 2; wdata_a = 8'h5A;
    req_b = 1; we_b = 0; addr_b = 2;
    tick(); tick(); tick();
    req_a = 0;
    tick();
    chk("t5_gnt_b", 32'(gnt_b_o[0]), 1);
    chk("t5_gnt_a", 32'(gnt_a_o[0]), 0);
    req_b = 0;
    tick(); tick();

    // 6: reset during a burst clears state and contents
    do_reset();
    req_a = 1; we_a = 1; addr_a = 3; wdata_a = 8'h3C;
    tick(); tick();
    rst = 1;
    tick();
    rst = 0; req_a = 0;
    chk("t6_gnt_a", 32'(gnt_a_o[0]), 0);
    tick();
    req_a = 1; we_a = 0; addr_a = 3;
    tick(); tick();
    chk("t6_rdata", 32'(rd_a_o[0]), 32'h00);
    req_a = 0;
    tick();

    // Random traffic; waiting requesters keep their request stable
    for (int n = 0; n < 400; n++) begin
      rst = ($urandom_range(63) == 0);
      if (!(req_a && m_owner[0] != 1)) begin
        req_a = ($urandom_range(3) != 0); we_a = 1'($urandom_range(1));
        addr_a = 2'($urandom_range(3)); wdata_a = 8'($urandom);
      end
      if (!(req_b && m_owner[0] != 2)) begin
        req_b = ($urandom_range(3) != 0); we_b = 1'($urandom_range(1));
        addr_b = 2'($urandom_range(3)); wdata_b = 8'($urandom);
      end
      tick();
    end
    rst = 0; req_a = 0; req_b = 0;
    tick(); tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
